// File: rtl/sprite_motion_ctrl.sv
// Sprite motion sequencer: owns sprite position/direction, bounces it off the screen edges in vblank.
// Latency: rom_addr/pix_en registered (1 cycle); position moves the cycle after the qualifying frame tick.
// No backpressure: follows the raster counters every cycle; run=0 freezes motion, restart overrides all.
module sprite_motion_ctrl #(
  parameter int H_RES     = 640,
  parameter int V_RES     = 480,
  parameter int IMG_W     = 100,
  parameter int IMG_H     = 100,
  parameter int X0        = 200,
  parameter int Y0        = 200,
  parameter int STEP      = 1,
  parameter int FRAME_DIV = 2
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic [9:0]  h_cnt_i,
  input  logic [9:0]  v_cnt_i,
  input  logic        valid_i,
  input  logic        run_i,
  input  logic        restart_i,
  output logic [9:0]  img_x_o,
  output logic [9:0]  img_y_o,
  output logic        dir_x_o,
  output logic        dir_y_o,
  output logic [13:0] rom_addr_o,
  output logic        pix_en_o,
  output logic        bounce_o,
  output logic        corner_o
);

  localparam logic [10:0] V_RES_C   = 11'(V_RES);
  localparam logic [10:0] X_MAX     = 11'(H_RES - IMG_W);
  localparam logic [10:0] Y_MAX     = 11'(V_RES - IMG_H);
  localparam logic [10:0] STEP_C    = 11'(STEP);
  localparam logic [10:0] IMG_W_M1  = 11'(IMG_W - 1);
  localparam logic [10:0] IMG_H_M1  = 11'(IMG_H - 1);
  localparam logic [13:0] ADDR_LAST = 14'(IMG_W * IMG_H - 1);
  localparam logic [7:0]  DIV_LAST  = 8'(FRAME_DIV - 1);
  localparam logic [9:0]  X0_C      = 10'(X0);
  localparam logic [9:0]  Y0_C      = 10'(Y0);

  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_WAIT = 2'd1,
    S_STEP = 2'd2
  } state_t;

  state_t      state_q;
  logic [9:0]  img_x_q, img_y_q;
  logic        dir_x_q, dir_y_q;
  logic [7:0]  frame_cnt_q;
  logic [13:0] rom_addr_q;
  logic        pix_en_q, bounce_q, corner_q;

  logic        tick, area, h_in, v_in;
  logic [10:0] h_ext, v_ext, x_ext, y_ext;
  logic [9:0]  img_x_d, img_y_d;
  logic        dir_x_d, dir_y_d, rev_x, rev_y;
  logic [13:0] rom_addr_d;

  // One axis step in 11-bit arithmetic: returns {reversed, new_dir, new_pos}; clamps at 0 and lim.
  function automatic logic [11:0] axis_next(input logic [9:0] pos, input logic dir,
                                            input logic [10:0] lim);
    logic [10:0] p;
    logic [10:0] nxt;
    logic [11:0] r;
    p   = {1'b0, pos};
    nxt = p + STEP_C;
    if (!dir) begin
      if (nxt >= lim) r = {1'b1, 1'b1, lim[9:0]};
      else            r = {1'b0, 1'b0, nxt[9:0]};
    end else begin
      if (p <= STEP_C) begin
        r = {1'b1, 1'b0, 10'd0};
      end else begin
        nxt = p - STEP_C;
        r   = {1'b0, 1'b1, nxt[9:0]};
      end
    end
    return r;
  endfunction

  // Frame tick, sprite area qualifier and the candidate next position for both axes.
  always_comb begin
    h_ext = {1'b0, h_cnt_i};
    v_ext = {1'b0, v_cnt_i};
    x_ext = {1'b0, img_x_q};
    y_ext = {1'b0, img_y_q};
    tick  = (v_ext == V_RES_C) && (h_cnt_i == 10'd0);
    h_in  = (h_ext >= x_ext) && (h_ext <= x_ext + IMG_W_M1);
    v_in  = (v_ext >= y_ext) && (v_ext <= y_ext + IMG_H_M1);
    area  = h_in && v_in && valid_i;
    {rev_x, dir_x_d, img_x_d} = axis_next(img_x_q, dir_x_q, X_MAX);
    {rev_y, dir_y_d, img_y_d} = axis_next(img_y_q, dir_y_q, Y_MAX);
  end

  // ROM address: restarts every frame tick, advances once per in-area pixel, wraps after the last texel.
  always_comb begin
    rom_addr_d = rom_addr_q;
    if (tick) begin
      rom_addr_d = 14'd0;
    end else if (area) begin
      rom_addr_d = (rom_addr_q == ADDR_LAST) ? 14'd0 : rom_addr_q + 14'd1;
    end
  end

  // Address and area qualifier registers; pix_en lines up with the ROM's registered output.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rom_addr_q <= 14'd0;
      pix_en_q   <= 1'b0;
    end else begin
      rom_addr_q <= rom_addr_d;
      pix_en_q   <= area;
    end
  end

  // Motion FSM: counts frame ticks, steps position in vblank, restart overrides everything.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= S_WAIT;
      img_x_q     <= X0_C;
      img_y_q     <= Y0_C;
      dir_x_q     <= 1'b0;
      dir_y_q     <= 1'b0;
      frame_cnt_q <= 8'd0;
      bounce_q    <= 1'b0;
      corner_q    <= 1'b0;
    end else begin
      bounce_q <= 1'b0;
      corner_q <= 1'b0;
      if (restart_i) begin
        img_x_q     <= X0_C;
        img_y_q     <= Y0_C;
        dir_x_q     <= 1'b0;
        dir_y_q     <= 1'b0;
        frame_cnt_q <= 8'd0;
        state_q     <= run_i ? S_WAIT : S_HOLD;
      end else begin
        case (state_q)
          S_HOLD: begin
            if (run_i) state_q <= S_WAIT;
          end
          S_WAIT: begin
            if (!run_i) begin
              state_q <= S_HOLD;
            end else if (tick) begin
              if (frame_cnt_q == DIV_LAST) begin
                frame_cnt_q <= 8'd0;
                state_q     <= S_STEP;
              end else begin
                frame_cnt_q <= frame_cnt_q + 8'd1;
              end
            end
          end
          S_STEP: begin
            img_x_q  <= img_x_d;
            img_y_q  <= img_y_d;
            dir_x_q  <= dir_x_d;
            dir_y_q  <= dir_y_d;
            bounce_q <= rev_x | rev_y;
            corner_q <= rev_x & rev_y;
            state_q  <= S_WAIT;
          end
          default: state_q <= S_WAIT;
        endcase
      end
    end
  end

  assign img_x_o    = img_x_q;
  assign img_y_o    = img_y_q;
  assign dir_x_o    = dir_x_q;
  assign dir_y_o    = dir_y_q;
  assign rom_addr_o = rom_addr_q;
  assign pix_en_o   = pix_en_q;
  assign bounce_o   = bounce_q;
  assign corner_o   = corner_q;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Bench for sprite_motion_ctrl: four instances with different start points/steps share one raster.
// Position expectations come from a per-instance reference of the bounce rules, queued per tick.
// ROM address/pix_en expectations are queued per driven pixel and popped after the clock edge.
module tb_sprite_motion_ctrl;

  localparam int V_RES = 480;

  logic        clk     = 1'b0;
  logic        reset_n = 1'b0;
  logic [9:0]  h_cnt   = 10'd5;
  logic [9:0]  v_cnt   = 10'd500;
  logic        valid   = 1'b0;
  logic        run     = 1'b0;
  logic [3:0]  restart = 4'd0;

  logic [9:0]  img_x_w    [4];
  logic [9:0]  img_y_w    [4];
  logic        dir_x_w    [4];
  logic        dir_y_w    [4];
  logic [13:0] rom_addr_w [4];
  logic        pix_en_w   [4];
  logic        bounce_w   [4];
  logic        corner_w   [4];

  int n_total = 0;
  int n_bad   = 0;

  int x0_p   [4] = '{200, 538, 539, 540};
  int y0_p   [4] = '{200, 300, 379, 10};
  int step_p [4] = '{1, 3, 1, 1};
  int div_p  [4] = '{2, 1, 1, 1};

  int mx [4], my [4], mdx [4], mdy [4], mcnt [4];
  int m_rom;
  int obs_b [4], obs_c [4];

  typedef struct {int inst; int x; int y; int dx; int dy; int b; int c;} pos_exp_t;
  typedef struct {int pix; int addr;} rom_exp_t;
  pos_exp_t pos_q [$];
  rom_exp_t rom_q [$];

  always #5 clk = ~clk;

  sprite_motion_ctrl #(.X0(200), .Y0(200), .STEP(1), .FRAME_DIV(2)) dut0 (
    .clk_i(clk), .reset_ni(reset_n), .h_cnt_i(h_cnt), .v_cnt_i(v_cnt), .valid_i(valid),
    .run_i(run), .restart_i(restart[0]), .img_x_o(img_x_w[0]), .img_y_o(img_y_w[0]),
    .dir_x_o(dir_x_w[0]), .dir_y_o(dir_y_w[0]), .rom_addr_o(rom_addr_w[0]),
    .pix_en_o(pix_en_w[0]), .bounce_o(bounce_w[0]), .corner_o(corner_w[0]));

  sprite_motion_ctrl #(.X0(538), .Y0(300), .STEP(3), .FRAME_DIV(1)) dut1 (
    .clk_i(clk), .reset_ni(reset_n), .h_cnt_i(h_cnt), .v_cnt_i(v_cnt), .valid_i(valid),
    .run_i(run), .restart_i(restart[1]), .img_x_o(img_x_w[1]), .img_y_o(img_y_w[1]),
    .dir_x_o(dir_x_w[1]), .dir_y_o(dir_y_w[1]), .rom_addr_o(rom_addr_w[1]),
    .pix_en_o(pix_en_w[1]), .bounce_o(bounce_w[1]), .corner_o(corner_w[1]));

  sprite_motion_ctrl #(.X0(539), .Y0(379), .STEP(1), .FRAME_DIV(1)) dut2 (
    .clk_i(clk), .reset_ni(reset_n), .h_cnt_i(h_cnt), .v_cnt_i(v_cnt), .valid_i(valid),
    .run_i(run), .restart_i(restart[2]), .img_x_o(img_x_w[2]), .img_y_o(img_y_w[2]),
    .dir_x_o(dir_x_w[2]), .dir_y_o(dir_y_w[2]), .rom_addr_o(rom_addr_w[2]),
    .pix_en_o(pix_en_w[2]), .bounce_o(bounce_w[2]), .corner_o(corner_w[2]));

  sprite_motion_ctrl #(.X0(540), .Y0(10), .STEP(1), .FRAME_DIV(1)) dut3 (
    .clk_i(clk), .reset_ni(reset_n), .h_cnt_i(h_cnt), .v_cnt_i(v_cnt), .valid_i(valid),
    .run_i(run), .restart_i(restart[3]), .img_x_o(img_x_w[3]), .img_y_o(img_y_w[3]),
    .dir_x_o(dir_x_w[3]), .dir_y_o(dir_y_w[3]), .rom_addr_o(rom_addr_w[3]),
    .pix_en_o(pix_en_w[3]), .bounce_o(bounce_w[3]), .corner_o(corner_w[3]));

  task automatic chk(input string tag, input int got, input int want);
    n_total++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset(input int i);
    mx[i] = x0_p[i]; my[i] = y0_p[i]; mdx[i] = 0; mdy[i] = 0; mcnt[i] = 0;
  endtask

  task automatic model_axis(input int p, input int d, input int stp, input int lim,
                            output int np, output int nd, output int rev);
    if (d == 0) begin
      if (p + stp >= lim) begin np = lim; nd = 1; rev = 1; end
      else begin np = p + stp; nd = 0; rev = 0; end
    end else begin
      if (p <= stp) begin np = 0; nd = 0; rev = 1; end
      else begin np = p - stp; nd = 1; rev = 0; end
    end
  endtask

  task automatic chk_reset_all(input string tag);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_x%0d", tag, i), int'(img_x_w[i]), x0_p[i]);
      chk($sformatf("%s_y%0d", tag, i), int'(img_y_w[i]), y0_p[i]);
      chk($sformatf("%s_dir%0d", tag, i), int'({dir_x_w[i], dir_y_w[i]}), 0);
      chk($sformatf("%s_rom%0d", tag, i), int'(rom_addr_w[i]), 0);
      chk($sformatf("%s_pix%0d", tag, i), int'(pix_en_w[i]), 0);
      chk($sformatf("%s_pulse%0d", tag, i), int'({bounce_w[i], corner_w[i]}), 0);
    end
  endtask

  // Drive one frame tick followed by blanking; rst_inst >= 0 pulses that instance's restart
  // in the cycle its FSM sits in S_STEP.
  task automatic do_tick(input int rst_inst);
    pos_exp_t e;
    int nx, ny, ndx, ndy, rx, ry;
    h_cnt = 10'd0; v_cnt = 10'(V_RES); valid = 1'b0;
    m_rom = 0;
    for (int i = 0; i < 4; i++) begin
      e.b = 0; e.c = 0;
      if (run) begin
        if (mcnt[i] == div_p[i] - 1) begin
          mcnt[i] = 0;
          model_axis(mx[i], mdx[i], step_p[i], 540, nx, ndx, rx);
          model_axis(my[i], mdy[i], step_p[i], 380, ny, ndy, ry);
          mx[i] = nx; mdx[i] = ndx; my[i] = ny; mdy[i] = ndy;
          e.b = (rx | ry); e.c = (rx & ry);
        end else begin
          mcnt[i] = mcnt[i] + 1;
        end
      end
      if (i == rst_inst) begin
        model_reset(i);
        e.b = 0; e.c = 0;
      end
      e.inst = i; e.x = mx[i]; e.y = my[i]; e.dx = mdx[i]; e.dy = mdy[i];
      pos_q.push_back(e);
    end
    cyc();
    chk("rom_at_tick", int'(rom_addr_w[0]), m_rom);
    h_cnt = 10'd1;
    if (rst_inst >= 0) restart[rst_inst] = 1'b1;
    cyc();
    restart = 4'd0;
    while (pos_q.size() > 0) begin
      e = pos_q.pop_front();
      chk($sformatf("x%0d", e.inst), int'(img_x_w[e.inst]), e.x);
      chk($sformatf("y%0d", e.inst), int'(img_y_w[e.inst]), e.y);
      chk($sformatf("dx%0d", e.inst), int'(dir_x_w[e.inst]), e.dx);
      chk($sformatf("dy%0d", e.inst), int'(dir_y_w[e.inst]), e.dy);
      chk($sformatf("bounce%0d", e.inst), int'(bounce_w[e.inst]), e.b);
      chk($sformatf("corner%0d", e.inst), int'(corner_w[e.inst]), e.c);
      obs_b[e.inst] = int'(bounce_w[e.inst]);
      obs_c[e.inst] = int'(corner_w[e.inst]);
    end
    h_cnt = 10'd2;
    cyc();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("pulse_end%0d", i), int'({bounce_w[i], corner_w[i]}), 0);
    end
    h_cnt = 10'd5; v_cnt = 10'd500;
  endtask

  // Drive a raster window around instance 0's sprite; checks pix_en/rom_addr every pixel.
  task automatic raster(input int v_lo, input int v_hi, output int n_pix);
    rom_exp_t e;
    bit a;
    n_pix = 0;
    for (int v = v_lo; v <= v_hi; v++) begin
      for (int h = 197; h <= 303; h++) begin
        h_cnt = 10'(h); v_cnt = 10'(v); valid = 1'b1;
        a = (h >= mx[0]) && (h <= mx[0] + 99) && (v >= my[0]) && (v <= my[0] + 99);
        if (a) m_rom = (m_rom == 9999) ? 0 : m_rom + 1;
        e.pix = int'(a); e.addr = m_rom;
        rom_q.push_back(e);
        cyc();
        e = rom_q.pop_front();
        chk("pix_en", int'(pix_en_w[0]), e.pix);
        chk("rom_addr", int'(rom_addr_w[0]), e.addr);
        if (pix_en_w[0]) n_pix++;
      end
    end
    valid = 1'b0; h_cnt = 10'd5; v_cnt = 10'd500;
    cyc();
  endtask

  initial begin
    int n;
    int x_seq [4] = '{200, 201, 201, 202};
    for (int i = 0; i < 4; i++) model_reset(i);
    m_rom = 0;
    repeat (2) cyc();
    chk_reset_all("reset");

    reset_n = 1'b1; run = 1'b1;
    repeat (2) cyc();

    // Full sprite frame at (200,200): 10000 pixels, address wraps back to 0.
    raster(198, 302, n);
    chk("frame_pix_cnt", n, 10000);
    chk("rom_wrapped", int'(rom_addr_w[0]), 0);
    // Partial line so the following tick has a non-zero address to clear.
    raster(200, 200, n);
    chk("line_pix_cnt", n, 100);
    chk("rom_line_end", int'(rom_addr_w[0]), 100);

    // Four frames: every-other-frame stepping, edge clamps, corner hit.
    for (int t = 0; t < 4; t++) begin
      do_tick(-1);
      chk($sformatf("seq_x0_%0d", t), int'(img_x_w[0]), x_seq[t]);
      chk($sformatf("seq_dir0_%0d", t), int'({dir_x_w[0], dir_y_w[0]}), 0);
      if (t == 0) begin
        chk("clamp_x1", int'(img_x_w[1]), 540);
        chk("clamp_dx1", int'(dir_x_w[1]), 1);
        chk("clamp_bounce1", obs_b[1], 1);
        chk("clamp_corner1", obs_c[1], 0);
        chk("corner_x2", int'(img_x_w[2]), 540);
        chk("corner_y2", int'(img_y_w[2]), 380);
        chk("corner_dirs2", int'({dir_x_w[2], dir_y_w[2]}), 3);
        chk("corner_bounce2", obs_b[2], 1);
        chk("corner_corner2", obs_c[2], 1);
      end
      if (t == 1) chk("back_x1", int'(img_x_w[1]), 537);
    end

    // Motion frozen for five frames, then resumes FRAME_DIV ticks after run rises.
    run = 1'b0;
    repeat (3) cyc();
    for (int t = 0; t < 5; t++) begin
      do_tick(-1);
      chk("hold_x0", int'(img_x_w[0]), 202);
      chk("hold_y0", int'(img_y_w[0]), 202);
    end
    run = 1'b1;
    repeat (2) cyc();
    do_tick(-1);
    chk("resume1_x0", int'(img_x_w[0]), 202);
    do_tick(-1);
    chk("resume2_x0", int'(img_x_w[0]), 203);

    // Restart colliding with S_STEP at (540,10).
    restart[3] = 1'b1;
    cyc();
    restart = 4'd0;
    model_reset(3);
    chk("pre_step_x3", int'(img_x_w[3]), 540);
    chk("pre_step_y3", int'(img_y_w[3]), 10);
    do_tick(3);
    chk("rs_x3", int'(img_x_w[3]), 540);
    chk("rs_y3", int'(img_y_w[3]), 10);
    chk("rs_dir3", int'({dir_x_w[3], dir_y_w[3]}), 0);
    chk("rs_bounce3", obs_b[3], 0);

    // Asynchronous reset mid-line while inside the sprite area.
    h_cnt = 10'd250; v_cnt = 10'd250; valid = 1'b1;
    repeat (3) cyc();
    chk("pre_rst_pix0", int'(pix_en_w[0]), 1);
    reset_n = 1'b0;
    #1;
    chk_reset_all("async");
    valid = 1'b0; h_cnt = 10'd5; v_cnt = 10'd500;
    cyc();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) model_reset(i);
    m_rom = 0;
    repeat (2) cyc();
    do_tick(-1);
    do_tick(-1);
    chk("post_rst_x0", int'(img_x_w[0]), 201);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
